ps2_scancode_rx: RTL and testbench
==================================

# ps2_scancode_rx

Parametrised PS/2 keyboard receiver. It runs entirely in the system clock domain and oversamples the keyboard's clock and data lines instead of clocking on the keyboard clock. It checks start, odd-parity and stop bits, enforces a frame timeout, and folds the 0xE0 (extended) and 0xF0 (break) prefixes into one key event per keystroke. Events are buffered in a small FIFO with a valid/ready output toward the game-control logic.

## Interface
- SYNC_STAGES, 2: synchroniser flops on ps2_clk and ps2_data (≥2).
- FILTER_LEN, 4: consecutive identical samples required before the filtered ps2_clk changes (≥1).
- TIMEOUT_CYCLES, 50000: clk cycles allowed between falling edges inside a frame (≈1 ms at 50 MHz).
- FIFO_DEPTH, 4: event buffer entries (power of two, ≥2).
- CHECK_PARITY, 1: 1 = discard bytes with bad parity; 0 = ignore the parity bit.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw keyboard clock, asynchronous.
- ps2_data  in  1  raw keyboard data, asynchronous.
- key_ready  in  1  consumer accepts the head event.
- key_valid  out  1  FIFO non-empty; head event presented.
- key_code  out  8  scan code of head event.
- key_break  out  1  head event is a release (F0 prefix seen).
- key_ext  out  1  head event is extended (E0 prefix seen).
- parity_err  out  1  one-cycle pulse: byte discarded for parity.
- frame_err  out  1  one-cycle pulse: bad stop bit or timeout.
- overflow  out  1  one-cycle pulse: event dropped, FIFO full.

## Operation
- Both inputs pass through SYNC_STAGES flops. The filtered clock (reset value 1) takes a new synchronised value only after FILTER_LEN consecutive equal samples.
- Sample event: one-cycle strobe on a 1→0 transition of the filtered clock. Data is taken from the synchronised (unfiltered) ps2_data in that cycle.
- Frame FSM, one state change per sample event:
  - IDLE: data 0 → DATA with bit index 0. Data 1 → stay in IDLE; not an error.
  - DATA: shift in LSB first. After bit 7 → PARITY.
  - PARITY: latch the bit → STOP.
  - STOP: data 1 and (parity OK or CHECK_PARITY=0) → byte done. Stop bit 0 → frame_err. Bad parity with CHECK_PARITY=1 → parity_err. Every case returns to IDLE.
  - Parity OK means XOR of the 8 data bits and the parity bit equals 1.
- Timeout: a counter clears on every sample event and in IDLE. In any other state, reaching TIMEOUT_CYCLES−1 forces IDLE, pulses frame_err and discards partial bits.
- Prefix decode on a completed byte:
  - 0xE0 sets the ext flag.
  - 0xF0 sets the brk flag.
  - Any other byte pushes {ext, brk, byte} and then clears both flags.
- Any parity_err or frame_err also clears both flags.
- FIFO:
  - Push is accepted if not full, or if full and a pop occurs in the same cycle.
  - Otherwise the event is dropped and overflow pulses.
  - Pop occurs when key_valid & key_ready.
  - Outputs show the head entry and hold stable while key_valid=1 and key_ready=0.
- Reset (any state, including mid-frame): FSM → IDLE, flags cleared, FIFO emptied, filter state = 1, timeout counter = 0. All outputs are 0. Partial frames are lost.

## Timing
- A raw ps2_clk fall reaches the sample event after SYNC_STAGES+FILTER_LEN clk cycles (±1).
- Completed non-prefix byte with the FIFO empty: key_valid rises on the clk cycle after the stop-bit sample event.
- Pop: key_valid falls, or the next entry appears, one cycle after the handshake.
- The error pulses and overflow are exactly one clk cycle wide and are asserted the cycle after the offending sample event or timeout.
- Glitches on ps2_clk shorter than FILTER_LEN cycles produce no sample event.
- Prefix bytes alone never assert key_valid.

## Test plan
- Frame 0x1C (data 0,0,1,1,1,0,0,0, parity 0, stop 1) at a 10 kHz PS/2 clock → one event: code 0x1C, brk 0, ext 0; no error pulses.
- Sequence F0 1C, then E0 75, then E0 F0 75 → three events: (1C,b1,e0), (75,b0,e1), (75,b1,e1).
- 0x1C sent with parity 1 and CHECK_PARITY=1 → parity_err pulse, no event. Repeat with CHECK_PARITY=0 → event 0x1C.
- Stop bit 0, and separately 5 bits followed by silence > TIMEOUT_CYCLES → one frame_err each. A following valid 0x1C frame is decoded correctly.
- key_ready held 0 while 6 codes arrive (FIFO_DEPTH=4) → 4 events held, 2 overflow pulses. Drained in order with ready=1, the first 4 codes come out.
- Reset asserted mid-frame after 4 bits → all outputs 0. The next full 0x1C frame yields exactly one correct event. 2-cycle glitches on ps2_clk → no effect.

Source files
------------

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver running in the system clock domain.
// Oversamples ps2_clk/ps2_data, deglitches the clock, frames
// start/data/parity/stop bits with a timeout, folds E0/F0 prefixes into a
// single key event and buffers events in a small FIFO.
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   ps2_clk, ps2_data      raw asynchronous keyboard lines
//   key_ready              consumer accepts the head event
//   key_valid/code/break/ext  head event of the FIFO
//   parity_err, frame_err, overflow  one-cycle error pulses
module ps2_scancode_rx #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter bit          CHECK_PARITY   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       key_ready,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_ext,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);

    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned EW  = 10;  // {ext, brk, code}

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   filt_q, filt_d;
    logic [FCW-1:0]         fcnt_q, fcnt_d;
    state_t                 state_q, state_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic [TCW-1:0]         tcnt_q, tcnt_d;
    logic                   ext_q, ext_d;
    logic                   brk_q, brk_d;
    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic [EW-1:0]          mem_d [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   key_valid_q, key_valid_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overflow_q, overflow_d;

    // Next-state logic for synchroniser, filter, framer, decoder and FIFO
    always_comb begin
        logic clk_s;
        logic data_s;
        logic sample;
        logic byte_done;
        logic push_req;
        logic push_ok;
        logic pop;
        logic full;

        clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        filt_d       = filt_q;
        fcnt_d       = '0;
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        par_d        = par_q;
        tcnt_d       = '0;
        ext_d        = ext_q;
        brk_d        = brk_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        overflow_d   = 1'b0;
        byte_done    = 1'b0;
        push_req     = 1'b0;
        push_ok      = 1'b0;
        clk_s        = clk_sync_q[SYNC_STAGES-1];
        data_s       = data_sync_q[SYNC_STAGES-1];

        // Clock filter: adopt a new level only after FILTER_LEN equal samples
        if (clk_s != filt_q) begin
            if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_d = clk_s;
            end else begin
                fcnt_d = fcnt_q + FCW'(1);
            end
        end
        sample = filt_q & ~filt_d;

        // Frame sequencing, one step per filtered falling edge
        if (sample) begin
            case (state_q)
                S_IDLE: begin
                    if (!data_s) begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_d   = data_s;
                    state_d = S_STOP;
                end
                default: begin
                    state_d = S_IDLE;
                    if (!data_s) begin
                        frame_err_d = 1'b1;
                    end else if (CHECK_PARITY && !(^{shift_q, par_q})) begin
                        parity_err_d = 1'b1;
                    end else begin
                        byte_done = 1'b1;
                    end
                end
            endcase
        end

        // Inter-edge timeout; counter idles at zero outside a frame
        if (state_q != S_IDLE && !sample) begin
            if (tcnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
                state_d     = S_IDLE;
                frame_err_d = 1'b1;
            end else begin
                tcnt_d = tcnt_q + TCW'(1);
            end
        end

        // Prefix folding
        if (parity_err_d || frame_err_d) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_done) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                push_req = 1'b1;
                ext_d    = 1'b0;
                brk_d    = 1'b0;
            end
        end

        // Event FIFO; a full FIFO still accepts when the head leaves this cycle
        pop  = key_valid_q & key_ready;
        full = (count_q == CW'(FIFO_DEPTH));
        if (push_req) begin
            if (!full || pop) begin
                push_ok          = 1'b1;
                mem_d[wr_ptr_q]  = {ext_q, brk_q, shift_q};
                wr_ptr_d         = wr_ptr_q + AW'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        key_valid_d = (count_d != '0);
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q   <= '1;
            data_sync_q  <= '1;
            filt_q       <= 1'b1;
            fcnt_q       <= '0;
            state_q      <= S_IDLE;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tcnt_q       <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            key_valid_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            filt_q       <= filt_d;
            fcnt_q       <= fcnt_d;
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tcnt_q       <= tcnt_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            key_valid_q  <= key_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
        end
    end

    logic [EW-1:0] head;
    assign head       = mem_q[rd_ptr_q];
    assign key_valid  = key_valid_q;
    assign key_code   = head[7:0];
    assign key_break  = head[8];
    assign key_ext    = head[9];
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: two instances (parity checked / ignored) share
// the PS/2 lines; a frame-level model predicts events and error pulses.
module tb_ps2_scancode_rx;

    localparam int unsigned HALF  = 20;
    localparam int unsigned TMO   = 200;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_ready = 1'b0;
    logic [1:0] kv, kb, ke, pe, fe, ov;
    logic [7:0] kc0, kc1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ps2_scancode_rx #(.SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(TMO),
                      .FIFO_DEPTH(DEPTH), .CHECK_PARITY(1'b1)) dut0 (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_ready(key_ready), .key_valid(kv[0]), .key_code(kc0),
        .key_break(kb[0]), .key_ext(ke[0]), .parity_err(pe[0]),
        .frame_err(fe[0]), .overflow(ov[0]));

    ps2_scancode_rx #(.SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(TMO),
                      .FIFO_DEPTH(DEPTH), .CHECK_PARITY(1'b0)) dut1 (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_ready(key_ready), .key_valid(kv[1]), .key_code(kc1),
        .key_break(kb[1]), .key_ext(ke[1]), .parity_err(pe[1]),
        .frame_err(fe[1]), .overflow(ov[1]));

    // Reference model state, per instance
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    bit m_ext[2];
    bit m_brk[2];
    int exp_pe[2], exp_fe[2], exp_ov[2];
    int obs_pe[2], obs_fe[2], obs_ov[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // Frame-level outcome: errors clear prefixes, E0/F0 set them, others enqueue
    task automatic model_frame(input int d, input logic [7:0] b, input bit bp,
                               input bit bs, input bit trunc, input bit chk);
        logic [9:0] ev;
        if (trunc || bs) begin
            exp_fe[d]++;
            m_ext[d] = 0; m_brk[d] = 0;
        end else if (bp && chk) begin
            exp_pe[d]++;
            m_ext[d] = 0; m_brk[d] = 0;
        end else if (b == 8'hE0) begin
            m_ext[d] = 1;
        end else if (b == 8'hF0) begin
            m_brk[d] = 1;
        end else begin
            ev = {m_ext[d], m_brk[d], b};
            if (qsize(d) < int'(DEPTH)) begin
                if (d == 0) q0.push_back(ev); else q1.push_back(ev);
            end else begin
                exp_ov[d]++;
            end
            m_ext[d] = 0; m_brk[d] = 0;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic glitch();
        ps2_clk = 1'b0;
        wait_cyc(2);
        ps2_clk = 1'b1;
    endtask

    // Sends the first nbits of a frame; the model is updated at the last fall
    task automatic send_frame(input logic [7:0] b, input bit bp, input bit bs,
                              input int nbits, input bit gl, input bit modeled);
        logic [10:0] fr;
        fr = {~bs, (~^b) ^ bp, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            if (modeled && i == nbits - 1) begin
                model_frame(0, b, bp, bs, nbits < 11, 1'b1);
                model_frame(1, b, bp, bs, nbits < 11, 1'b0);
            end
            wait_cyc(HALF);
            ps2_clk = 1'b1;
            if (gl && i == 3) begin
                wait_cyc(4);
                glitch();
            end
        end
        wait_cyc(HALF);
        ps2_data = 1'b1;
        wait_cyc(HALF);
    endtask

    // Pop checker and pulse counters
    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                if (pe[d]) obs_pe[d]++;
                if (fe[d]) obs_fe[d]++;
                if (ov[d]) obs_ov[d]++;
            end
            if (kv[0] && key_ready) begin
                if (q0.size() == 0) check_eq("spurious_event0", 32'(kc0), 32'hFFFF);
                else begin
                    check_eq("event0", 32'({ke[0], kb[0], kc0}), 32'(q0[0]));
                    void'(q0.pop_front());
                end
            end
            if (kv[1] && key_ready) begin
                if (q1.size() == 0) check_eq("spurious_event1", 32'(kc1), 32'hFFFF);
                else begin
                    check_eq("event1", 32'({ke[1], kb[1], kc1}), 32'(q1[0]));
                    void'(q1.pop_front());
                end
            end
        end
    end

    task automatic settle(input string tag);
        wait_cyc(TMO + 40);
        for (int d = 0; d < 2; d++) begin
            check_eq({tag, "_parity_err"}, 32'(obs_pe[d]), 32'(exp_pe[d]));
            check_eq({tag, "_frame_err"}, 32'(obs_fe[d]), 32'(exp_fe[d]));
            check_eq({tag, "_overflow"}, 32'(obs_ov[d]), 32'(exp_ov[d]));
            if (key_ready) check_eq({tag, "_pending"}, 32'(qsize(d)), 32'd0);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        @(negedge clk);
        check_eq({tag, "_valid"}, 32'(kv), 32'd0);
        check_eq({tag, "_code"}, 32'({kc1, kc0}), 32'd0);
        check_eq({tag, "_brk_ext"}, 32'({kb, ke}), 32'd0);
        check_eq({tag, "_pulses"}, 32'({pe, fe, ov}), 32'd0);
    endtask

    logic [7:0] code;
    logic [9:0] head0;

    initial begin
        wait_cyc(5);
        check_outputs_zero("reset");
        reset = 1'b0;
        key_ready = 1'b1;
        wait_cyc(10);

        // Plain make code, then prefixed sequences
        send_frame(8'h1C, 0, 0, 11, 0, 1);
        settle("single");
        send_frame(8'hF0, 0, 0, 11, 0, 1);
        send_frame(8'h1C, 0, 0, 11, 1, 1);
        send_frame(8'hE0, 0, 0, 11, 0, 1);
        send_frame(8'h75, 0, 0, 11, 0, 1);
        send_frame(8'hE0, 0, 0, 11, 1, 1);
        send_frame(8'hF0, 0, 0, 11, 0, 1);
        send_frame(8'h75, 0, 0, 11, 0, 1);
        settle("prefix");

        // Parity, stop and timeout errors, then recovery
        send_frame(8'h1C, 1, 0, 11, 0, 1);
        settle("parity");
        send_frame(8'hE0, 0, 0, 11, 0, 1);
        send_frame(8'h1C, 0, 1, 11, 0, 1);
        settle("stop");
        send_frame(8'h1C, 0, 0, 5, 0, 1);
        settle("timeout");
        send_frame(8'h1C, 0, 0, 11, 0, 1);
        settle("recover");

        // Back-pressure: 6 codes into a 4-deep FIFO
        key_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            code = 8'(8'h10 + i);
            send_frame(code, 0, 0, 11, 0, 1);
        end
        @(negedge clk);
        head0 = q0[0];
        check_eq("hold_valid", 32'(kv), 32'd3);
        check_eq("hold_head", 32'({ke[0], kb[0], kc0}), 32'(head0));
        wait_cyc(50);
        @(negedge clk);
        check_eq("hold_stable", 32'({ke[0], kb[0], kc0}), 32'(head0));
        check_eq("hold_depth", 32'(q0.size()), 32'(DEPTH));
        settle("full");
        key_ready = 1'b1;
        settle("drain");

        // Reset in the middle of a frame with a pending prefix
        send_frame(8'hE0, 0, 0, 11, 0, 1);
        ps2_data = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_cyc(HALF); ps2_clk = 1'b0;
            wait_cyc(HALF); ps2_clk = 1'b1;
            ps2_data = 1'b1;
        end
        reset = 1'b1;
        wait_cyc(2);
        check_outputs_zero("midreset");
        m_ext[0] = 0; m_brk[0] = 0; m_ext[1] = 0; m_brk[1] = 0;
        q0.delete(); q1.delete();
        reset = 1'b0;
        wait_cyc(5);
        glitch();
        wait_cyc(10);
        send_frame(8'h1C, 0, 0, 11, 1, 1);
        settle("post_reset");

        // Randomised traffic
        for (int n = 0; n < 30; n++) begin
            int r;
            int nb;
            bit bp, bs, gl;
            r = int'($urandom_range(0, 7));
            if (r == 0) code = 8'hE0;
            else if (r == 1) code = 8'hF0;
            else begin
                code = 8'($urandom_range(0, 255));
                if (code == 8'hE0 || code == 8'hF0) code = code ^ 8'h01;
            end
            bp = ($urandom_range(0, 7) == 0);
            bs = ($urandom_range(0, 15) == 0);
            gl = $urandom_range(0, 1) == 1;
            nb = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 10)) : 11;
            send_frame(code, bp, bs, nb, gl, 1);
            if (nb < 11) wait_cyc(TMO + 20);
        end
        settle("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
